acia_6850: RTL and testbench
============================

// Module: acia_6850
// PURPOSE
//  Functional MC6850 ACIA replacing the fixed-status ACIA mock: real TX/RX shifters, 8 word formats,
//  /1 /16 /64 clock select, status/IRQ logic, optional RX/TX FIFOs deeper than the 6850's 1-byte latches.
//  Sits on the 6502 bus beside the system VIA; serial pins go to the RS423/cassette path.
// PARAMETERS
//  PRESCALE      13  clk2MHz cycles per serial tick (2MHz/13 ~ 16x9600)
//  RX_DEPTH      1   RX holding entries (1 = genuine 6850), power of two, 1..16
//  TX_DEPTH      1   TX holding entries, power of two, 1..16
// PORTS
//  clk2MHz  in   1  system clock; all state on posedge
//  RESET    in   1  asynchronous, active-high reset
//  nACIA    in   1  chip select, active low
//  RS       in   1  register select: 0 = control/status, 1 = TX/RX data
//  RnW      in   1  1 = read, 0 = write
//  DATABUS  inout 8 driven with read data while ~nACIA & RnW, else 8'hzz
//  RXD      in   1  serial in, idle high
//  nCTS     in   1  clear to send, active low
//  nDCD     in   1  carrier detect, active low
//  TXD      out  1  serial out, idle high
//  nRTS     out  1  request to send, active low
//  nIRQ     out  1  interrupt, active low
// BEHAVIOUR
//  Bus access: one access per posedge with nACIA=0; read side effects (pops, flag clears) at that edge.
//  RESET: CR=8'h03 (master reset), FIFOs empty, shifters idle, TXD=1, nRTS=1, nIRQ=1, status=0 except CTS.
//  CR[1:0]: 00 /1, 01 /16, 10 /64, 11 master reset. While 11: both shifters idle, FIFOs flushed,
//   TXD=1, all status except CTS/DCD-input forced 0; frame in progress aborted next cycle.
//  CR[4:2] word: 0 7E2,1 7O2,2 7E1,3 7O1,4 8N2,5 8N1,6 8E1,7 8O1. Sampled at start of each frame.
//  CR[6:5]: 00 nRTS=0 TIE=0; 01 nRTS=0 TIE=1; 10 nRTS=1 TIE=0; 11 nRTS=0, TXD held 0 (break).
//  CR[7]: RIE.
//  Tick: prescaler counts 0..PRESCALE-1, tick pulse at wrap; divider (1/16/64 ticks) forms bit time.
//  TX: when shifter idle, TX FIFO non-empty, nCTS=0 and not break -> pop, send start, LSB-first data,
//   parity, stop(s); next byte follows back-to-back with no idle bit. nCTS high never aborts a frame in flight.
//  RX /16,/64: falling RXD starts count; re-sampled at half bit (8/32 ticks) - high = false start, back to idle;
//   then each bit sampled at mid-bit. /1: sampled on every tick, no start validation.
//  RX complete: push {data,FE,PE}; 7-bit words zero-fill bit 7. FIFO full -> char dropped, OVRN set.
//  FE = stop bit 0; PE = parity mismatch (never in 8N*); both reflect FIFO head entry.
//  Status: b0 RDRF(rx non-empty) b1 TDRE(tx not full & nCTS=0) b2 DCD b3 CTS(=nCTS) b4 FE b5 OVRN b6 PE b7 IRQ.
//  DCD: set on nDCD rising edge; cleared by status read followed by data read, unless nDCD still high.
//  Data read: returns head, pops, clears OVRN. Empty read returns last value, no pop.
//  Data write: push; full -> ignored, no flag. Push+pop same edge: count unchanged.
//  IRQ = RIE&(RDRF|OVRN|DCD) | TIE&TDRE; nIRQ=~IRQ, registered (1-cycle latency).
//  Read data combinational from registered state (no wait states).
// STRUCTURE
//  acia_defs.vh: localparams for CR field encodings, word-format table, status bit indices.
//  Sub-module acia_fifo (WIDTH, DEPTH): sync FIFO, full/empty/count, flush input; used for RX (10b) and TX (8b).
//  TX/RX shifters, prescaler and status/IRQ logic inline.
// TESTING
//  Reset, read status -> 8'h00 with nCTS=0 (8'h08 with nCTS=1); TXD=1, nIRQ=1.
//  CR=8'h15 (/16 8N1), write 8'h55, TXD loopback to RXD -> RDRF after 10 bit times, data read 8'h55, FE=PE=0.
//  CR=8'h09 (/16 7E1), RX 7'h41 with wrong parity -> status b6=1, data 8'h41.
//  RX_DEPTH=1: receive 8'hA1, 8'hB2 unread -> OVRN=1, read returns 8'hA1, then OVRN=0, RDRF=0.
//  CR=8'hB5 (RIE,TIE): TDRE & nCTS=0 -> nIRQ=0; nCTS=1 -> nIRQ=1; write CR=8'h03 mid-frame -> TXD=1 next cycle.
//  RX_DEPTH=4: four bytes back-to-back, no overrun, read in order; RXD low glitch 4 ticks -> no char.

Source files
------------

// File: rtl/acia_6850_pkg.sv
// rtl/acia_6850_pkg.sv - control register encodings, status bit indices and word-format helpers
package acia_6850_pkg;

    typedef enum logic [1:0] {
        CDS_DIV1   = 2'b00,
        CDS_DIV16  = 2'b01,
        CDS_DIV64  = 2'b10,
        CDS_MRESET = 2'b11
    } cds_t;

    typedef enum logic [1:0] {
        TXC_RTS_LO     = 2'b00,
        TXC_RTS_LO_TIE = 2'b01,
        TXC_RTS_HI     = 2'b10,
        TXC_BREAK      = 2'b11
    } txc_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA
    } rx_state_t;

    localparam int ST_RDRF = 0;
    localparam int ST_TDRE = 1;
    localparam int ST_DCD  = 2;
    localparam int ST_CTS  = 3;
    localparam int ST_FE   = 4;
    localparam int ST_OVRN = 5;
    localparam int ST_PE   = 6;
    localparam int ST_IRQ  = 7;
    localparam int CR_RIE  = 7;

    // Word formats 0..7: 7E2 7O2 7E1 7O1 8N2 8N1 8E1 8O1
    function automatic logic fmt_has_par(input logic [2:0] f);
        return !(f == 3'd4 || f == 3'd5);
    endfunction

    function automatic logic fmt_stop2(input logic [2:0] f);
        return (f == 3'd0 || f == 3'd1 || f == 3'd4);
    endfunction

    // Index of the (first) stop bit within the received data/parity/stop sequence
    function automatic logic [3:0] fmt_last(input logic [2:0] f);
        return (f[2] ? 4'd8 : 4'd7) + {3'b000, fmt_has_par(f)};
    endfunction

    function automatic logic par_bit(input logic [2:0] f, input logic [7:0] d);
        return (f[2] ? ^d : ^d[6:0]) ^ f[0];
    endfunction

    // Bit 0 goes out first; unused upper bits stay 1 so the line idles high
    function automatic logic [10:0] tx_frame(input logic [2:0] f, input logic [7:0] d);
        logic [10:0] fr;
        fr    = '1;
        fr[0] = 1'b0;
        if (f[2]) begin
            fr[8:1] = d;
            if (fmt_has_par(f)) fr[9] = par_bit(f, d);
        end else begin
            fr[7:1] = d[6:0];
            if (fmt_has_par(f)) fr[8] = par_bit(f, d);
        end
        return fr;
    endfunction

    function automatic logic [3:0] tx_len(input logic [2:0] f);
        return 4'd2 + (f[2] ? 4'd8 : 4'd7) + {3'b000, fmt_has_par(f)} + {3'b000, fmt_stop2(f)};
    endfunction

    function automatic logic [5:0] div_max(input cds_t c);
        case (c)
            CDS_DIV1:  return 6'd0;
            CDS_DIV16: return 6'd15;
            default:   return 6'd63;
        endcase
    endfunction

    function automatic logic [5:0] half_max(input cds_t c);
        return (c == CDS_DIV16) ? 6'd7 : 6'd31;
    endfunction

endpackage

// File: rtl/acia_6850_fifo.sv
// rtl/acia_6850_fifo.sv - synchronous show-ahead FIFO with flush, used for RX and TX holding
module acia_6850_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [0:(1<<AW)-1];
    logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (cnt_q == 5'd0);
    assign full    = (cnt_q == 5'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves on the same edge
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rp_q];

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (flush) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wp_d = nxt(wp_q);
            if (do_pop)  rp_d = nxt(rp_q);
            if (do_push && !do_pop)      cnt_d = cnt_q + 5'd1;
            else if (!do_push && do_pop) cnt_d = cnt_q - 5'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wp_q] <= wdata;
    end

endmodule

// File: rtl/acia_6850.sv
// rtl/acia_6850.sv - MC6850-compatible ACIA: shifters, clock select, status/IRQ, optional deep FIFOs
module acia_6850
    import acia_6850_pkg::*;
#(
    parameter int PRESCALE = 13,
    parameter int RX_DEPTH = 1,
    parameter int TX_DEPTH = 1
) (
    input  logic       clk2MHz,
    input  logic       RESET,
    input  logic       nACIA,
    input  logic       RS,
    input  logic       RnW,
    inout  wire  [7:0] DATABUS,
    input  logic       RXD,
    input  logic       nCTS,
    input  logic       nDCD,
    output logic       TXD,
    output logic       nRTS,
    output logic       nIRQ
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [7:0]  cr_q, cr_d;
    logic [PW-1:0] presc_q, presc_d;
    logic        rxd_s1_q, rxd_s2_q, ndcd_s1_q, ndcd_s2_q, ndcd_p_q;
    logic        tx_busy_q, tx_busy_d;
    logic [10:0] tx_sr_q, tx_sr_d;
    logic [3:0]  tx_left_q, tx_left_d;
    logic [5:0]  tx_cnt_q, tx_cnt_d;
    rx_state_t   rx_state_q, rx_state_d;
    logic [5:0]  rx_cnt_q, rx_cnt_d;
    logic [3:0]  rx_idx_q, rx_idx_d;
    logic [9:0]  rx_sr_q, rx_sr_d;
    logic [2:0]  rx_fmt_q, rx_fmt_d;
    logic        ovr_q, ovr_d, dcd_q, dcd_d, arm_q, arm_d, irq_q, irq_d;
    logic [7:0]  rdr_q, rdr_d;

    cds_t        cds;
    txc_t        txc;
    logic        mr, brk, tie, rie, tick;
    logic        rd_en, data_rd, stat_rd, data_wr, cr_wr;
    logic        tx_empty, tx_full, tx_pop, tx_free, tx_end;
    logic [7:0]  tx_head;
    logic        rx_empty, rx_full, rx_pop, rx_push, rx_pe, rx_fe, rx_pbit;
    logic [7:0]  rx_data;
    logic [9:0]  rx_head;
    logic        rdrf, tdre;
    logic [7:0]  status, rd_data;

    assign cds  = cds_t'(cr_q[1:0]);
    assign txc  = txc_t'(cr_q[6:5]);
    assign mr   = (cds == CDS_MRESET);
    assign brk  = (txc == TXC_BREAK);
    assign tie  = (txc == TXC_RTS_LO_TIE);
    assign rie  = cr_q[CR_RIE];
    assign tick = (presc_q == PW'(PRESCALE - 1));

    assign rd_en   = !nACIA && RnW;
    assign data_rd = rd_en && RS;
    assign stat_rd = rd_en && !RS;
    assign data_wr = !nACIA && !RnW && RS;
    assign cr_wr   = !nACIA && !RnW && !RS;

    acia_6850_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk2MHz), .rst(RESET), .flush(mr), .push(data_wr), .wdata(DATABUS),
        .pop(tx_pop), .rdata(tx_head), .full(tx_full), .empty(tx_empty)
    );

    acia_6850_fifo #(.WIDTH(10), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk2MHz), .rst(RESET), .flush(mr), .push(rx_push), .wdata({rx_data, rx_fe, rx_pe}),
        .pop(rx_pop), .rdata(rx_head), .full(rx_full), .empty(rx_empty)
    );

    // Transmitter: the next frame loads on the last bit's closing tick, so frames run back-to-back
    assign tx_end  = tick && (tx_cnt_q == div_max(cds));
    assign tx_free = !tx_busy_q || (tx_end && tx_left_q == 4'd1);
    assign tx_pop  = tx_free && !tx_empty && !nCTS && !brk && !mr;

    always_comb begin
        tx_busy_d = tx_busy_q;
        tx_sr_d   = tx_sr_q;
        tx_left_d = tx_left_q;
        tx_cnt_d  = tx_cnt_q;
        if (mr) begin
            tx_busy_d = 1'b0;
            tx_cnt_d  = '0;
        end else if (tx_pop) begin
            tx_busy_d = 1'b1;
            tx_sr_d   = tx_frame(cr_q[4:2], tx_head);
            tx_left_d = tx_len(cr_q[4:2]);
            tx_cnt_d  = '0;
        end else if (tx_busy_q && tick) begin
            if (tx_end) begin
                tx_sr_d   = {1'b1, tx_sr_q[10:1]};
                tx_left_d = tx_left_q - 4'd1;
                tx_cnt_d  = '0;
                if (tx_left_q == 4'd1) tx_busy_d = 1'b0;
            end else begin
                tx_cnt_d = tx_cnt_q + 6'd1;
            end
        end
    end

    assign TXD  = mr ? 1'b1 : brk ? 1'b0 : tx_busy_q ? tx_sr_q[0] : 1'b1;
    assign nRTS = mr || (txc == TXC_RTS_HI);

    // Receiver: /16 and /64 confirm the start bit at half-bit, then sample every bit mid-cell
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_sr_d    = rx_sr_q;
        rx_fmt_d   = rx_fmt_q;
        rx_push    = 1'b0;
        if (mr) begin
            rx_state_d = RX_IDLE;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    rx_cnt_d = '0;
                    rx_idx_d = '0;
                    rx_fmt_d = cr_q[4:2];
                    if (cds == CDS_DIV1) begin
                        if (tick && !rxd_s2_q) rx_state_d = RX_DATA;
                    end else if (!rxd_s2_q) begin
                        rx_state_d = RX_START;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        if (rx_cnt_q == half_max(cds)) begin
                            rx_cnt_d   = '0;
                            rx_state_d = rxd_s2_q ? RX_IDLE : RX_DATA;
                        end else begin
                            rx_cnt_d = rx_cnt_q + 6'd1;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        if (rx_cnt_q == div_max(cds)) begin
                            rx_cnt_d          = '0;
                            rx_sr_d[rx_idx_q] = rxd_s2_q;
                            if (rx_idx_q == fmt_last(rx_fmt_q)) begin
                                rx_push    = 1'b1;
                                rx_state_d = RX_IDLE;
                            end else begin
                                rx_idx_d = rx_idx_q + 4'd1;
                            end
                        end else begin
                            rx_cnt_d = rx_cnt_q + 6'd1;
                        end
                    end
                end
                default: rx_state_d = RX_IDLE;
            endcase
        end
        rx_data = rx_fmt_q[2] ? rx_sr_d[7:0] : {1'b0, rx_sr_d[6:0]};
        rx_pbit = rx_fmt_q[2] ? rx_sr_d[8] : rx_sr_d[7];
        rx_pe   = fmt_has_par(rx_fmt_q) && (rx_pbit != par_bit(rx_fmt_q, rx_data));
        rx_fe   = !rx_sr_d[fmt_last(rx_fmt_q)];
    end

    assign rx_pop = data_rd && !rx_empty && !mr;
    assign rdrf   = !rx_empty && !mr;
    assign tdre   = !tx_full && !nCTS && !mr;

    always_comb begin
        status          = '0;
        status[ST_RDRF] = rdrf;
        status[ST_TDRE] = tdre;
        status[ST_DCD]  = dcd_q;
        status[ST_CTS]  = nCTS;
        status[ST_FE]   = rdrf && rx_head[1];
        status[ST_OVRN] = ovr_q;
        status[ST_PE]   = rdrf && rx_head[0];
        irq_d           = !mr && ((rie && (rdrf || ovr_q || dcd_q)) || (tie && tdre));
        status[ST_IRQ]  = irq_d;
        rd_data         = RS ? (rx_empty ? rdr_q : rx_head[9:2]) : status;

        cr_d  = cr_wr ? DATABUS : cr_q;
        rdr_d = rx_pop ? rx_head[9:2] : rdr_q;
        presc_d = tick ? '0 : presc_q + 1'b1;

        ovr_d = ovr_q;
        if (mr)                                ovr_d = 1'b0;
        else if (rx_push && rx_full && !rx_pop) ovr_d = 1'b1;
        else if (data_rd)                      ovr_d = 1'b0;

        // DCD only clears after a status read has seen it and a data read follows
        dcd_d = dcd_q;
        arm_d = arm_q;
        if (mr) begin
            dcd_d = ndcd_s2_q;
            arm_d = 1'b0;
        end else if (ndcd_s2_q && !ndcd_p_q) begin
            dcd_d = 1'b1;
        end else if (stat_rd && dcd_q) begin
            arm_d = 1'b1;
        end else if (data_rd) begin
            arm_d = 1'b0;
            if (arm_q && !ndcd_s2_q) dcd_d = 1'b0;
        end
    end

    assign DATABUS = rd_en ? rd_data : 8'hzz;
    assign nIRQ    = !irq_q;

    always_ff @(posedge clk2MHz or posedge RESET) begin
        if (RESET) begin
            cr_q       <= 8'h03;
            presc_q    <= '0;
            rxd_s1_q   <= 1'b1;
            rxd_s2_q   <= 1'b1;
            ndcd_s1_q  <= 1'b0;
            ndcd_s2_q  <= 1'b0;
            ndcd_p_q   <= 1'b0;
            tx_busy_q  <= 1'b0;
            tx_sr_q    <= '1;
            tx_left_q  <= '0;
            tx_cnt_q   <= '0;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_sr_q    <= '0;
            rx_fmt_q   <= '0;
            ovr_q      <= 1'b0;
            dcd_q      <= 1'b0;
            arm_q      <= 1'b0;
            irq_q      <= 1'b0;
            rdr_q      <= '0;
        end else begin
            cr_q       <= cr_d;
            presc_q    <= presc_d;
            rxd_s1_q   <= RXD;
            rxd_s2_q   <= rxd_s1_q;
            ndcd_s1_q  <= nDCD;
            ndcd_s2_q  <= ndcd_s1_q;
            ndcd_p_q   <= ndcd_s2_q;
            tx_busy_q  <= tx_busy_d;
            tx_sr_q    <= tx_sr_d;
            tx_left_q  <= tx_left_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_sr_q    <= rx_sr_d;
            rx_fmt_q   <= rx_fmt_d;
            ovr_q      <= ovr_d;
            dcd_q      <= dcd_d;
            arm_q      <= arm_d;
            irq_q      <= irq_d;
            rdr_q      <= rdr_d;
        end
    end

endmodule

// File: tb/tb_acia_6850.sv
// tb/tb_acia_6850.sv - self-checking bench for acia_6850 (RX depth 1 and 4 instances, scoreboard)
module tb_acia_6850;

    localparam int PS  = 4;
    localparam int BIT = 16 * PS;

    logic       clk = 1'b0;
    logic       rst, cs1, cs4, rs, rnw, rxd_drv, loop, ncts, ndcd;
    logic [7:0] wdata;
    wire  [7:0] db1, db4;
    logic       txd1, txd4, nrts1, nrts4, nirq1, nirq4, rxd1;
    int         total = 0, bad = 0, cyc = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rxd1 = loop ? txd1 : rxd_drv;
    assign db1  = (!cs1 && !rnw) ? wdata : 8'hzz;
    assign db4  = (!cs4 && !rnw) ? wdata : 8'hzz;

    acia_6850 #(.PRESCALE(PS), .RX_DEPTH(1), .TX_DEPTH(1)) dut1 (
        .clk2MHz(clk), .RESET(rst), .nACIA(cs1), .RS(rs), .RnW(rnw), .DATABUS(db1),
        .RXD(rxd1), .nCTS(ncts), .nDCD(ndcd), .TXD(txd1), .nRTS(nrts1), .nIRQ(nirq1)
    );

    acia_6850 #(.PRESCALE(PS), .RX_DEPTH(4), .TX_DEPTH(1)) dut4 (
        .clk2MHz(clk), .RESET(rst), .nACIA(cs4), .RS(rs), .RnW(rnw), .DATABUS(db4),
        .RXD(rxd_drv), .nCTS(ncts), .nDCD(ndcd), .TXD(txd4), .nRTS(nrts4), .nIRQ(nirq4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input int which, input logic r, input logic [7:0] d);
        @(negedge clk);
        rs = r; rnw = 1'b0; wdata = d;
        if (which == 1) cs1 = 1'b0; else cs4 = 1'b0;
        @(negedge clk);
        cs1 = 1'b1; cs4 = 1'b1; rnw = 1'b1;
    endtask

    task automatic bus_read(input int which, input logic r, output logic [7:0] d);
        @(negedge clk);
        rs = r; rnw = 1'b1;
        if (which == 1) cs1 = 1'b0; else cs4 = 1'b0;
        #2 d = (which == 1) ? db1 : db4;
        @(negedge clk);
        cs1 = 1'b1; cs4 = 1'b1;
    endtask

    task automatic check_status(input int which, input string tag, input logic [7:0] exp);
        logic [7:0] st;
        bus_read(which, 1'b0, st);
        check(tag, st, exp);
    endtask

    task automatic read_pop(input int which, input string tag);
        logic [7:0] d;
        bus_read(which, 1'b1, d);
        if (exp_q.size() == 0) check({tag, "_sb_empty"}, 1, 0);
        else check(tag, d, exp_q.pop_front());
    endtask

    // par: 0 none, 1 even, 2 odd; flip corrupts the parity bit
    task automatic send_byte(input logic [7:0] d, input int nbits, input int par, input bit flip);
        logic [7:0] m;
        logic       p;
        m = (nbits == 7) ? {1'b0, d[6:0]} : d;
        p = ^m;
        if (par == 2) p = ~p;
        if (flip) p = ~p;
        rxd_drv = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            rxd_drv = m[i];
            repeat (BIT) @(negedge clk);
        end
        if (par != 0) begin
            rxd_drv = p;
            repeat (BIT) @(negedge clk);
        end
        rxd_drv = 1'b1;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic wait_rdrf(input int which, input string tag, output logic [7:0] st);
        st = 8'h00;
        for (int n = 0; n < 1000; n++) begin
            bus_read(which, 1'b0, st);
            if (st[0]) break;
        end
        if (!st[0]) check({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        logic [7:0] st, d;
        int         t0;
        rst = 1'b1; cs1 = 1'b1; cs4 = 1'b1; rs = 1'b0; rnw = 1'b1; wdata = 8'h00;
        rxd_drv = 1'b1; loop = 1'b0; ncts = 1'b0; ndcd = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_txd", txd1, 1);
        check("rst_nirq", nirq1, 1);
        check("rst_nrts", nrts1, 1);
        check_status(1, "rst_status_cts0", 8'h00);
        ncts = 1'b1;
        check_status(1, "rst_status_cts1", 8'h08);
        ncts = 1'b0;
        check_status(4, "rst_status_dut4", 8'h00);

        // /16 8N1 loopback
        bus_write(1, 1'b0, 8'h15);
        check("nrts_on", nrts1, 0);
        loop = 1'b1;
        exp_q.push_back(8'h55);
        bus_write(1, 1'b1, 8'h55);
        t0 = cyc;
        wait_rdrf(1, "loop", st);
        check("loop_rdrf_time", (cyc - t0 >= 9 * BIT) && (cyc - t0 <= 11 * BIT), 1);
        check("loop_status", st, 8'h03);
        read_pop(1, "loop_data");
        check_status(1, "loop_status_after", 8'h02);
        repeat (BIT) @(negedge clk);
        loop = 1'b0;

        // /16 7E1 with a corrupted parity bit
        bus_write(1, 1'b0, 8'h09);
        exp_q.push_back(8'h41);
        send_byte(8'h41, 7, 1, 1'b1);
        wait_rdrf(1, "pe", st);
        check("pe_status", st, 8'h43);
        read_pop(1, "pe_data");
        check_status(1, "pe_status_after", 8'h02);

        // one-entry RX holding: the second unread byte is lost
        bus_write(1, 1'b0, 8'h15);
        exp_q.push_back(8'hA1);
        send_byte(8'hA1, 8, 0, 1'b0);
        send_byte(8'hB2, 8, 0, 1'b0);
        repeat (BIT) @(negedge clk);
        check_status(1, "ovrn_status", 8'h23);
        read_pop(1, "ovrn_data");
        check_status(1, "ovrn_status_after", 8'h02);

        // interrupts, CTS gating and master reset mid-frame
        bus_write(1, 1'b0, 8'hB5);
        repeat (3) @(negedge clk);
        check("irq_tdre", nirq1, 0);
        check_status(1, "irq_status", 8'h82);
        ncts = 1'b1;
        repeat (3) @(negedge clk);
        check("irq_cts_high", nirq1, 1);
        check_status(1, "irq_cts_status", 8'h08);
        ncts = 1'b0;
        bus_write(1, 1'b1, 8'h00);
        repeat (3 * BIT) @(negedge clk);
        check("midframe_txd", txd1, 0);
        bus_write(1, 1'b0, 8'h03);
        check("mreset_txd", txd1, 1);
        repeat (2) @(negedge clk);
        check("mreset_nirq", nirq1, 1);
        check("mreset_nrts", nrts1, 1);
        check_status(1, "mreset_status", 8'h00);

        // four-entry RX holding: back-to-back bytes all kept
        bus_write(4, 1'b0, 8'h15);
        foreach (exp_q[i]) check("sb_leftover", 1, 0);
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(8'(i * 8'h11));
            send_byte(8'(i * 8'h11), 8, 0, 1'b0);
        end
        repeat (BIT) @(negedge clk);
        check_status(4, "fifo4_status", 8'h03);
        for (int i = 0; i < 4; i++) read_pop(4, "fifo4_data");
        check_status(4, "fifo4_status_after", 8'h02);

        rxd_drv = 1'b0;
        repeat (4 * PS) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check_status(4, "glitch_status", 8'h02);

        ndcd = 1'b1;
        repeat (4) @(negedge clk);
        ndcd = 1'b0;
        repeat (4) @(negedge clk);
        check_status(4, "dcd_status", 8'h06);
        bus_read(4, 1'b1, d);
        check("empty_read_last", d, 8'h44);
        check_status(4, "dcd_cleared", 8'h02);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
